alu_req_driver: RTL and testbench

- Clocked initiator that drives the ALU operand/command interface (operands A/B, 2-bit command; ALU returns ready, result-valid, result) from an upstream valid/ready request stream.
- Returns each ALU result on a downstream valid/ready response stream.
- Enforces one outstanding ALU operation, applies a response timeout, and counts completed transactions.
- Sits between a command source (sequencer, CPU-side shim or bench) and the alu block, replacing the unclocked stimulus module.

---
 rtl/alu_req_driver.sv | 181 ++++++++++++++++++
 tb/tb_alu_req_driver.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_driver.sv
// Clocked initiator for the ALU operand/command interface: one outstanding operation,
// response timeout, transaction counter. Optional result checker under ALU_REQ_CHECK_EN.
module alu_req_driver #(
  parameter int W       = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [W-1:0]     i_req_a,
  input  logic [W-1:0]     i_req_b,
  input  logic [1:0]       i_req_op,
  output logic [W-1:0]     o_alu_a,
  output logic [W-1:0]     o_alu_b,
  output logic [1:0]       o_alu_op,
  input  logic             i_alu_ready,
  input  logic             i_alu_res_valid,
  input  logic [W-1:0]     i_alu_result,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [W-1:0]     o_rsp_result,
  output logic             o_rsp_err,
  output logic             o_stray,
  output logic [CNT_W-1:0] o_txn_cnt
`ifdef ALU_REQ_CHECK_EN
  ,
  output logic             o_chk_err,
  output logic [CNT_W-1:0] o_chk_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int TW = 16;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic             req_ready_q, req_ready_d;
  logic [W-1:0]     alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [W-1:0]     rsp_result_q, rsp_result_d;
  logic             rsp_err_q, rsp_err_d;
  logic             stray_q, stray_d;
  logic [CNT_W-1:0] txn_cnt_q, txn_cnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;

  // NOTE: every _d starts from its _q so no path through this block can infer a latch.
  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    txn_cnt_d    = txn_cnt_q;
    tmo_d        = tmo_q;
    stray_d      = stray_q | (i_alu_res_valid && (state_q != WAIT));

    unique case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (i_req_valid && req_ready_q) begin
          alu_a_d     = i_req_a;
          alu_b_d     = i_req_b;
          alu_op_d    = i_req_op;
          req_ready_d = 1'b0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (i_alu_ready) begin
          tmo_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        tmo_d = tmo_q + TW'(1);
        // A result arriving on the timeout cycle still counts as a real result.
        if (i_alu_res_valid) begin
          rsp_result_d = i_alu_result;
          rsp_err_d    = 1'b0;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end else if (tmo_q == TMO_LAST) begin
          rsp_result_d = '0;
          rsp_err_d    = 1'b1;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          txn_cnt_d   = txn_cnt_q + CNT_W'(1);
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      stray_q      <= 1'b0;
      txn_cnt_q    <= '0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      stray_q      <= stray_d;
      txn_cnt_q    <= txn_cnt_d;
      tmo_q        <= tmo_d;
    end
  end

  assign o_req_ready  = req_ready_q;
  assign o_alu_a      = alu_a_q;
  assign o_alu_b      = alu_b_q;
  assign o_alu_op     = alu_op_q;
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_result = rsp_result_q;
  assign o_rsp_err    = rsp_err_q;
  assign o_stray      = stray_q;
  assign o_txn_cnt    = txn_cnt_q;

`ifdef ALU_REQ_CHECK_EN
  logic [W-1:0]     exp_res;
  logic             chk_err_q, chk_err_d;
  logic [CNT_W-1:0] chk_cnt_q, chk_cnt_d;

  always_comb begin
    unique case (alu_op_q)
      2'd0:    exp_res = alu_a_q + alu_b_q;
      2'd1:    exp_res = alu_a_q - alu_b_q;
      2'd2:    exp_res = alu_a_q & alu_b_q;
      default: exp_res = alu_a_q | alu_b_q;
    endcase
    chk_err_d = chk_err_q;
    chk_cnt_d = chk_cnt_q;
    if ((state_q == WAIT) && i_alu_res_valid && (i_alu_result != exp_res)) begin
      chk_err_d = 1'b1;
      if (!(&chk_cnt_q)) chk_cnt_d = chk_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chk_err_q <= 1'b0;
      chk_cnt_q <= '0;
    end else begin
      chk_err_q <= chk_err_d;
      chk_cnt_q <= chk_cnt_d;
    end
  end

  assign o_chk_err = chk_err_q;
  assign o_chk_cnt = chk_cnt_q;
`endif

endmodule

// File: tb/tb_alu_req_driver.sv
// Directed, table-driven bench for alu_req_driver (TIMEOUT=8) with a behavioural ALU.
module tb_alu_req_driver;
  localparam int W = 32;
  localparam int CNT_W = 16;
  localparam int TIMEOUT = 8;

  logic             clk, reset;
  logic             i_req_valid, o_req_ready;
  logic [W-1:0]     i_req_a, i_req_b;
  logic [1:0]       i_req_op;
  logic [W-1:0]     o_alu_a, o_alu_b;
  logic [1:0]       o_alu_op;
  logic             i_alu_ready, i_alu_res_valid;
  logic [W-1:0]     i_alu_result;
  logic             o_rsp_valid, i_rsp_ready;
  logic [W-1:0]     o_rsp_result;
  logic             o_rsp_err, o_stray;
  logic [CNT_W-1:0] o_txn_cnt;
`ifdef ALU_REQ_CHECK_EN
  logic             o_chk_err;
  logic [CNT_W-1:0] o_chk_cnt;
`endif

  alu_req_driver #(.W(W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_a(i_req_a), .i_req_b(i_req_b), .i_req_op(i_req_op),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op),
    .i_alu_ready(i_alu_ready), .i_alu_res_valid(i_alu_res_valid),
    .i_alu_result(i_alu_result),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_result(o_rsp_result), .o_rsp_err(o_rsp_err),
    .o_stray(o_stray),
`ifdef ALU_REQ_CHECK_EN
    .o_chk_err(o_chk_err), .o_chk_cnt(o_chk_cnt),
`endif
    .o_txn_cnt(o_txn_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b;
    logic [1:0]   op;
    int           stall;    // cycles with i_alu_ready=0 in ISSUE
    int           lat;      // WAIT cycle on which res_valid is driven (>TIMEOUT: never)
    int           hold;     // cycles of i_rsp_ready=0 in RESP
    bit           stray;    // pulse res_valid during RESP hold
    bit           bad;      // ALU returns bad_val instead of a correct result
    logic [W-1:0] bad_val;
    logic [W-1:0] exp_res;
    bit           exp_err;
    int           exp_cyc;  // accept edge to o_rsp_valid, in cycles
  } vec_t;

  int n_pass = 0, n_total = 0;
  logic [CNT_W-1:0] exp_txn = '0;
  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, b, input logic [1:0] op);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  function automatic vec_t mk(input logic [W-1:0] a, b, input logic [1:0] op,
                              input int stall, lat, hold, input bit stray, bad,
                              input logic [W-1:0] bad_val, exp_res,
                              input bit exp_err, input int exp_cyc);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.stall = stall; v.lat = lat; v.hold = hold;
    v.stray = stray; v.bad = bad; v.bad_val = bad_val; v.exp_res = exp_res;
    v.exp_err = exp_err; v.exp_cyc = exp_cyc;
    return v;
  endfunction

  task automatic run_txn(input int idx);
    vec_t v;
    int k, n;
    bit done;
    v = vecs[idx];
    i_req_a = v.a; i_req_b = v.b; i_req_op = v.op; i_req_valid = 1'b1;
    k = 0;
    while (!o_req_ready && k < 20) begin step(); k++; end
    if (!o_req_ready) check("req_ready_bound", 64'(o_req_ready), 64'd1);
    step();
    i_req_valid = 1'b0;
    check($sformatf("v%0d_alu_latched", idx), {o_alu_a, o_alu_b[29:0], o_alu_op},
          {v.a, v.b[29:0], v.op});
    i_alu_ready = 1'b0;
    for (int s = 0; s < v.stall; s++) begin
      step();
      check($sformatf("v%0d_issue_stall%0d", idx, s),
            {62'(o_alu_a == v.a && o_alu_b == v.b), o_rsp_valid, o_req_ready}, 64'b100);
    end
    i_alu_ready = 1'b1;
    step();
    i_alu_ready = 1'b0;
    n = 0; done = 1'b0;
    while (!done && n < 100) begin
      n++;
      if (n == v.lat) begin
        i_alu_res_valid = 1'b1;
        i_alu_result = v.bad ? v.bad_val : alu_fn(v.a, v.b, v.op);
      end
      step();
      i_alu_res_valid = 1'b0;
      done = o_rsp_valid;
    end
    if (!done) check("rsp_wait_bound", 64'(o_rsp_valid), 64'd1);
    check($sformatf("v%0d_rsp_cycles", idx), 64'(n), 64'(v.exp_cyc));
    check($sformatf("v%0d_rsp_result", idx), 64'(o_rsp_result), 64'(v.exp_res));
    check($sformatf("v%0d_rsp_err", idx), 64'(o_rsp_err), 64'(v.exp_err));
    i_rsp_ready = 1'b0;
    for (int h = 0; h < v.hold; h++) begin
      if (v.stray && h == 1) begin
        i_alu_res_valid = 1'b1;
        i_alu_result = 32'hDEAD_BEEF;
      end
      step();
      i_alu_res_valid = 1'b0;
      check($sformatf("v%0d_hold%0d", idx, h),
            {60'(o_rsp_result == v.exp_res), o_rsp_valid, o_req_ready,
             1'(o_txn_cnt == exp_txn), o_rsp_err}, {60'd1, 1'b1, 1'b0, 1'b1, v.exp_err});
    end
    if (v.stray) check($sformatf("v%0d_stray", idx), 64'(o_stray), 64'd1);
    i_rsp_ready = 1'b1;
    step();
    i_rsp_ready = 1'b0;
    exp_txn = exp_txn + CNT_W'(1);
    check($sformatf("v%0d_after_hs", idx), {46'd0, o_txn_cnt, o_rsp_valid, o_req_ready},
          {46'd0, exp_txn, 1'b0, 1'b1});
  endtask

  initial begin
    vecs[0]  = mk(32'd5, 32'd7, 2'd0, 0, 2, 0, 0, 0, 0, 32'd12, 0, 2);
    vecs[1]  = mk(32'd10, 32'd3, 2'd1, 10, 1, 0, 0, 0, 0, 32'd7, 0, 1);
    vecs[2]  = mk(32'hF0F0, 32'hFF00, 2'd2, 0, 3, 5, 1, 0, 0, 32'hF000, 0, 3);
    vecs[3]  = mk(32'hF0F0, 32'h0F0F, 2'd3, 0, 1, 0, 0, 0, 0, 32'hFFFF, 0, 1);
    vecs[4]  = mk(32'd0, 32'd1, 2'd1, 0, 1, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 1);
    vecs[5]  = mk(32'd3, 32'd4, 2'd0, 0, 99, 0, 0, 0, 0, 32'd0, 1, 8);
    vecs[6]  = mk(32'd3, 32'd4, 2'd0, 0, 8, 0, 0, 0, 0, 32'd7, 0, 8);
    vecs[7]  = mk(32'd9, 32'd9, 2'd3, 0, 9, 2, 0, 0, 0, 32'd0, 1, 8);
    vecs[8]  = mk(32'hFFFF_FFFF, 32'd1, 2'd0, 0, 2, 0, 0, 0, 0, 32'd0, 0, 2);
    vecs[9]  = mk(32'd1, 32'd1, 2'd0, 0, 1, 0, 0, 1, 32'd3, 32'd3, 0, 1);
    vecs[10] = mk(32'd2, 32'd2, 2'd0, 0, 1, 0, 0, 0, 0, 32'd4, 0, 1);

    reset = 1'b1; i_req_valid = 1'b0; i_req_a = '0; i_req_b = '0; i_req_op = '0;
    i_alu_ready = 1'b0; i_alu_res_valid = 1'b0; i_alu_result = '0; i_rsp_ready = 1'b0;
    repeat (3) step();
    check("reset_outputs", {o_req_ready, o_rsp_valid, o_rsp_err, o_stray, o_alu_op,
                            26'd0, 32'(o_txn_cnt)}, 64'd0);
    check("reset_data", {o_alu_a, o_rsp_result}, 64'd0);
    reset = 1'b0;
    step();
    check("ready_after_reset", {61'd0, o_req_ready, o_stray, o_rsp_valid}, 64'b100);

    for (int i = 0; i < 8; i++) run_txn(i);

    // Abort an operation mid-WAIT: no response may follow.
    i_req_a = 32'd1; i_req_b = 32'd2; i_req_op = 2'd0; i_req_valid = 1'b1;
    step();
    i_req_valid = 1'b0; i_alu_ready = 1'b1;
    step();
    i_alu_ready = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    check("midwait_reset_ctl", {o_req_ready, o_rsp_valid, o_rsp_err, o_stray, o_alu_op,
                                26'd0, 32'(o_txn_cnt)}, 64'd0);
    check("midwait_reset_data", {o_alu_a, o_rsp_result}, 64'd0);
    reset = 1'b0;
    exp_txn = '0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (o_rsp_valid) check("no_rsp_after_reset", 64'(o_rsp_valid), 64'd0);
    end
    check("idle_after_abort", {62'd0, o_req_ready, o_rsp_valid}, 64'b10);

`ifdef ALU_REQ_CHECK_EN
    run_txn(8);
    check("chk_clean", {47'd0, o_chk_err, o_chk_cnt}, 64'd0);
    run_txn(9);
    check("chk_mismatch", {47'd0, o_chk_err, o_chk_cnt}, {47'd0, 1'b1, 16'd1});
    run_txn(10);
    check("chk_no_change", {47'd0, o_chk_err, o_chk_cnt}, {47'd0, 1'b1, 16'd1});
`else
    for (int i = 8; i < 11; i++) run_txn(i);
`endif
    check("stray_clear", 64'(o_stray), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
